// File: rtl/lzc_iter.sv
// lzc_iter: iterative leading/trailing-zero counter.
// Scans a WIDTH-bit word CHUNK bits per cycle, starting at the MSB end, and
// stops at the first non-zero chunk. Trailing-zero requests are turned into
// leading-zero scans by bit-reversing the word when it is accepted.
// valid/ready handshakes on both sides; one word in flight at a time.
module lzc_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH+1)-1:0] out_count,
  output logic                       out_zero
);

  localparam int CW     = $clog2(WIDTH + 1);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    count;
  logic [IW-1:0]    idx;

  logic [WIDTH-1:0] in_rev;
  logic [CHUNK-1:0] chunk;
  logic [CW-1:0]    chunk_lz;

  // Handshake outputs decode directly from the registered state.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Bit-reversed copy of the input, used for trailing-zero requests.
  always_comb begin
    in_rev = '0;
    for (int i = 0; i < WIDTH; i++) begin
      in_rev[i] = in_data[WIDTH-1-i];
    end
  end

  assign chunk = sr[WIDTH-1 -: CHUNK];

  // Priority encoder: leading zeros of the top chunk (only used when non-zero).
  always_comb begin
    // NOTE: default assignment first, so no path leaves chunk_lz unassigned (no latch).
    chunk_lz = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk[i]) begin
        chunk_lz = CW'(CHUNK - 1 - i);
      end
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments throughout, so every register updates from pre-edge values.
      state     <= S_IDLE;
      sr        <= '0;
      count     <= '0;
      idx       <= '0;
      out_count <= '0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            sr    <= in_mode ? in_rev : in_data;
            count <= '0;
            idx   <= '0;
            state <= S_SCAN;
          end
        end

        S_SCAN: begin
          if (chunk == '0) begin
            count <= count + CW'(CHUNK);
            sr    <= sr << CHUNK;
            idx   <= idx + IW'(1);
            if (idx == IW'(NCHUNK - 1)) begin
              out_count <= CW'(WIDTH);
              out_zero  <= 1'b1;
              state     <= S_DONE;
            end
          end else begin
            out_count <= count + chunk_lz;
            out_zero  <= 1'b0;
            state     <= S_DONE;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lzc_iter.sv
// tb_lzc_iter: self-checking bench for lzc_iter (WIDTH=32, CHUNK=8).
// Directed corner words followed by randomised words in both modes with
// random backpressure, compared against a bit-walking reference model.
`timescale 1ns/1ps
module tb_lzc_iter;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    out_count;
  logic             out_zero;

  int n_checks = 0;
  int n_fails  = 0;

  lzc_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_zero  (out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference: walk bits from the MSB (mode 0) or LSB (mode 1) until a one.
  function automatic int ref_zeros(input logic [WIDTH-1:0] d, input logic m);
    int z = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (d[m ? i : WIDTH-1-i]) return z;
      z++;
    end
    return z;
  endfunction

  // Scan edges: one per chunk examined, up to and including the first non-zero one.
  function automatic int ref_scan_edges(input int z);
    int n = z / CHUNK + 1;
    return (n > NCHUNK) ? NCHUNK : n;
  endfunction

  // Push one word through, hold the result for 'hold' cycles, then consume it.
  // Entry and exit: 1 ns after a rising edge with the block idle.
  task automatic do_word(input string tag, input logic [WIDTH-1:0] d, input logic m,
                         input int hold, input bit rnd_ready);
    int  exp_z, exp_n, n;
    bit  seen;
    logic [CW-1:0] held_count;
    exp_z = ref_zeros(d, m);
    exp_n = ref_scan_edges(exp_z);

    check({tag, " in_ready idle"}, in_ready, 1);
    in_valid  = 1'b1;
    in_data   = d;
    in_mode   = m;
    out_ready = 1'b0;
    @(posedge clk); #1;                       // accept edge E0
    in_valid = 1'b0;
    in_data  = $urandom;                      // must not affect the result
    in_mode  = 1'($urandom);
    check({tag, " in_ready scan"}, in_ready, 0);

    n = 0;
    seen = 0;
    for (int c = 0; c < NCHUNK + 4 && !seen; c++) begin
      if (rnd_ready) out_ready = 1'($urandom);  // no effect outside DONE
      @(posedge clk); #1;
      n++;
      if (out_valid) seen = 1;
    end
    out_ready = 1'b0;
    check({tag, " out_valid timeout"}, seen, 1);
    check({tag, " latency"}, n, exp_n);
    check({tag, " out_count"}, out_count, exp_z);
    check({tag, " out_zero"}, out_zero, (exp_z == WIDTH) ? 1 : 0);
    held_count = out_count;

    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom);
      in_data  = $urandom;
      @(posedge clk); #1;
      check({tag, " hold valid"}, out_valid, 1);
      check({tag, " hold count"}, out_count, held_count);
      check({tag, " hold in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;                       // consume edge
    out_ready = 1'b0;
    check({tag, " out_valid after take"}, out_valid, 0);
    check({tag, " in_ready after take"}, in_ready, 1);
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset out_count", out_count, 0);
    check("reset out_zero", out_zero, 0);
    check("reset in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-reset in_ready", in_ready, 1);
    check("post-reset out_valid", out_valid, 0);

    // Directed corner words.
    do_word("lead 0x00010000", 32'h0001_0000, 1'b0, 0, 1'b0);
    do_word("lead 0x80000000", 32'h8000_0000, 1'b0, 0, 1'b0);
    do_word("trail 0x00010000", 32'h0001_0000, 1'b1, 0, 1'b0);
    do_word("trail 0x00000001", 32'h0000_0001, 1'b1, 0, 1'b0);
    do_word("lead zero", 32'h0, 1'b0, 0, 1'b0);
    do_word("trail zero", 32'h0, 1'b1, 0, 1'b0);
    do_word("lead 0x00000001", 32'h0000_0001, 1'b0, 0, 1'b0);
    do_word("trail 0x80000000", 32'h8000_0000, 1'b1, 0, 1'b0);
    do_word("backpressure", 32'h0000_0100, 1'b0, 5, 1'b0);
    do_word("after backpressure", 32'h00FF_0000, 1'b0, 0, 1'b0);

    // Reset in the middle of a scan: no result may appear.
    in_valid = 1'b1;
    in_data  = 32'h0;
    in_mode  = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst mid-scan out_valid", out_valid, 0);
    check("rst mid-scan in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < NCHUNK + 2; c++) begin
      @(posedge clk); #1;
      check("rst mid-scan no result", out_valid, 0);
    end

    // Reset while holding a result: outputs clear immediately.
    in_valid = 1'b1;
    in_data  = 32'h0001_0000;
    in_mode  = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre-rst done valid", out_valid, 1);
    check("pre-rst done count", out_count, 15);
    rst_n = 1'b0;
    #1;
    check("rst mid-done out_valid", out_valid, 0);
    check("rst mid-done out_count", out_count, 0);
    check("rst mid-done in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Randomised words, both modes, random backpressure.
    for (int k = 0; k < 200; k++) begin
      d = $urandom;
      case ($urandom_range(0, 3))
        0: d = d >> $urandom_range(0, 32);
        1: d = d << $urandom_range(0, 32);
        2: d = (d >> $urandom_range(0, 31)) << $urandom_range(0, 31);
        default: ;
      endcase
      do_word("random", d, 1'($urandom), $urandom_range(0, 3), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lzc_iter.md
# lzc_iter

Sequential, parametrised leading/trailing-zero counter with valid/ready handshakes on input and output. It scans a WIDTH-bit word CHUNK bits per cycle from the most significant end and exits early at the first non-zero chunk. This trades the area of a full combinational LZC tree for multi-cycle latency. It sits between the I2C register file and the hasher datapath, which need bit-position results from 32-bit words without a wide combinational cone.

## Interface

- WIDTH, 32: input word width; power of two, at least 2.
- CHUNK, 8: bits examined per scan cycle; power of two, divides WIDTH, CHUNK ≤ WIDTH.
- CW (localparam): $clog2(WIDTH+1), the count width (6 for WIDTH=32).
- NCHUNK (localparam): WIDTH/CHUNK.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  in_data/in_mode are valid.
- in_ready  out  1  block can accept a word (combinational from state).
- in_data  in  WIDTH  word to count.
- in_mode  in  1  0 = count leading zeros, 1 = count trailing zeros.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer takes the result.
- out_count  out  CW  number of zeros; range 0..WIDTH.
- out_zero  out  1  input word was all zeros; out_count = WIDTH.

## Operation

- States: IDLE, SCAN, DONE (registered state, async-reset to IDLE).
- **IDLE**
  - in_ready = 1; out_valid = 0.
  - On in_valid & in_ready:
    - Load shift register sr with in_data if in_mode = 0, or with bit-reversed in_data if in_mode = 1.
    - Clear count and chunk index idx.
    - Go to SCAN.
- **SCAN**
  - in_ready = 0. Examine sr[WIDTH-1 -: CHUNK].
  - If that chunk is all zero:
    - count += CHUNK; sr <<= CHUNK; idx += 1.
    - If idx was NCHUNK-1: latch out_zero = 1, out_count = WIDTH, go to DONE.
  - Else:
    - out_count = count + (priority-encoded leading zeros of the chunk, 0..CHUNK-1).
    - out_zero = 0; go to DONE.
- **DONE**
  - out_valid = 1; out_count and out_zero stay stable.
  - in_ready = 0; in_valid is ignored.
  - On out_ready, go to IDLE.
- Arithmetic: count and out_count are CW bits wide and never overflow (maximum WIDTH). idx is $clog2(NCHUNK) bits wide, minimum 1.
- in_data and in_mode are sampled only on the accepting edge. Later changes have no effect.
- CHUNK = WIDTH is legal: SCAN always lasts exactly one cycle.

## Timing

- Reset (rst_n low, asynchronous):
  - state = IDLE, out_valid = 0, out_count = 0, out_zero = 0, sr = 0, count = 0, idx = 0.
  - in_ready = 1 during and after reset.
- Accept at edge E0 (state becomes SCAN).
- Scan takes n = k+1 edges, where k is the index of the first non-zero chunk from the MSB end, or NCHUNK-1 for an all-zero word.
- out_valid rises after edge E0+n. Latency is n+1 cycles from the accept edge, minimum 2, maximum NCHUNK+1.
- Result is consumed on the edge where out_valid & out_ready. in_ready returns to 1 in the following cycle.
- Throughput: at most one word per n+2 cycles. There is no overlap of accept and deliver.
- Backpressure: out_ready low holds DONE indefinitely with outputs unchanged.
- Reset mid-SCAN or mid-DONE aborts the operation: no result is emitted, and out_valid drops immediately (asynchronous).
- out_ready asserted outside DONE has no effect.

## Test plan

All scenarios use WIDTH=32, CHUNK=8.

- Reset with in_valid=0: out_valid=0, out_count=0, out_zero=0, in_ready=1. Assert rst_n low mid-SCAN → out_valid stays 0, in_ready=1 on the next cycle, no result appears.
- Leading mode, in_data=0x0001_0000: out_count=15, out_zero=0, out_valid rises 3 cycles after the accept edge (n=2). Leading mode, in_data=0x8000_0000: out_count=0, n=1.
- Trailing mode, in_data=0x0001_0000: out_count=16, n=3. Trailing mode, in_data=0x0000_0001: out_count=0, n=1.
- in_data=0x0000_0000 in either mode: out_count=32, out_zero=1, n=4 (maximum latency of 5 cycles).
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and in_data.
  - out_valid/out_count stay stable and in_ready=0.
  - Assert out_ready → in_ready=1 next cycle; a new word 0x00FF_0000 (leading) yields 8.
- Randomised back-to-back words, both modes, random out_ready: every out_count matches a reference clz/ctz, with no dropped or duplicated results.
